// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Buffers bytes from the UART data-register write strobe in a small circular
// FIFO. It then sends each byte on txd as an 8N1 frame: one start bit, eight
// data bits LSB first, and one stop bit.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per bit period (>= 2)
//   DEPTH        : FIFO entries (power of 2, >= 2)
// Ports
//   clk      : single clock
//   rst      : synchronous, active-high reset; aborts any frame in flight
//   wr_en    : push wr_data this cycle
//   wr_data  : byte to transmit
//   clr_ovf  : clear the sticky overflow flag (a same-cycle drop wins)
//   txd      : registered serial output, idle high
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : bytes buffered, not counting the frame in flight
//   busy     : a frame is being shifted out
//   tx_done  : one-cycle pulse in the final cycle of each stop bit
//   overflow : sticky flag, set when a write is dropped
module uart_tx_queue #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     clr_ovf,
    output logic                     txd,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [BW-1:0]   baud_r, baud_s;
    logic [2:0]      bit_idx_r, bit_idx_s;
    logic [7:0]      sh_r, sh_s;
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r, count_s;
    logic            full_r, empty_r, ovf_r, ovf_s;
    logic            txd_r, txd_s, busy_r, done_r;
    logic            pop_s, push_s, drop_s, bit_end_s;
    logic [7:0]      mem_r [DEPTH];

    assign txd      = txd_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign busy     = busy_r;
    assign tx_done  = done_r;
    assign overflow = ovf_r;

    // Frame sequencing: next state, counters, shifter and the txd value for the next cycle
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_idx_s = bit_idx_r;
        sh_s      = sh_r;
        txd_s     = 1'b1;
        pop_s     = 1'b0;
        bit_end_s = (baud_r == BAUD_LAST);
        case (state_r)
            IDLE: begin
                if (!empty_r) begin
                    pop_s   = 1'b1;
                    sh_s    = mem_r[rd_ptr_r];
                    baud_s  = '0;
                    state_s = START;
                    txd_s   = 1'b0;
                end else begin
                    txd_s   = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s   = DATA;
                    baud_s    = '0;
                    bit_idx_s = 3'd0;
                    txd_s     = sh_r[0];
                end else begin
                    baud_s    = baud_r + 1'b1;
                    txd_s     = 1'b0;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                        txd_s   = 1'b1;
                    end else begin
                        // Next bit is sh_r[1]; the shifted value is registered alongside.
                        sh_s      = {1'b0, sh_r[7:1]};
                        bit_idx_s = bit_idx_r + 3'd1;
                        txd_s     = sh_r[1];
                    end
                end else begin
                    baud_s = baud_r + 1'b1;
                    txd_s  = sh_r[0];
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_s = '0;
                    if (!empty_r) begin
                        // Chain straight into the next start bit with no idle gap.
                        pop_s   = 1'b1;
                        sh_s    = mem_r[rd_ptr_r];
                        state_s = START;
                        txd_s   = 1'b0;
                    end else begin
                        state_s = IDLE;
                        txd_s   = 1'b1;
                    end
                end else begin
                    baud_s = baud_r + 1'b1;
                    txd_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = '0;
                txd_s   = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping: accept/drop decision, next count and sticky overflow
    always_comb begin
        push_s  = wr_en && (!full_r || pop_s);
        drop_s  = wr_en && full_r && !pop_s;
        count_s = count_r;
        ovf_s   = ovf_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + 1'b1;
            2'b01:   count_s = count_r - 1'b1;
            default: count_s = count_r;
        endcase
        if (drop_s) begin
            ovf_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // State, pointers and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            sh_r      <= 8'h00;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            ovf_r     <= 1'b0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_idx_r <= bit_idx_s;
            sh_r      <= sh_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r   <= count_s;
            full_r    <= (count_s == DEPTH_C);
            empty_r   <= (count_s == '0);
            ovf_r     <= ovf_s;
            txd_r     <= txd_s;
            busy_r    <= (state_s != IDLE);
            // Asserted for the cycle that will be the last one of a stop bit.
            done_r    <= (state_s == STOP) && (baud_s == BAUD_LAST);
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       txd, full, empty, busy, tx_done, overflow;
    logic [2:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    // Reference model: pending bytes, frame in flight and its cycle position
    logic [7:0] m_q[$];
    bit         m_fly = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf = 1'b0;

    uart_tx_queue #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .txd(txd), .full(full), .empty(empty),
        .count(count), .busy(busy), .tx_done(tx_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame line level from position: start bit, 8 data bits LSB first, stop bit.
    function automatic logic m_txd();
        if (!m_fly)           return 1'b1;
        if (m_pos < CPB)      return 1'b0;
        if (m_pos < 9 * CPB)  return m_byte[(m_pos - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic tick(input logic we, input logic [7:0] d, input logic co, input logic r);
        bit pop, acc;
        wr_en = we; wr_data = d; clr_ovf = co; rst = r;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_fly = 1'b0; m_pos = 0; m_ovf = 1'b0;
        end else begin
            pop = (m_q.size() > 0) && (!m_fly || m_pos == FRAME - 1);
            acc = we && ((m_q.size() < DEPTH) || pop);
            if (pop) begin
                m_byte = m_q.pop_front();
                m_fly = 1'b1; m_pos = 0;
            end else if (m_fly) begin
                if (m_pos == FRAME - 1) m_fly = 1'b0;
                else m_pos++;
            end
            if (acc) m_q.push_back(d);
            if (we && !acc) m_ovf = 1'b1;
            else if (co) m_ovf = 1'b0;
        end
        #1;
        check_eq("txd", txd, m_txd());
        check_eq("count", count, m_q.size());
        check_eq("busy", busy, m_fly);
        check_eq("tx_done", tx_done, m_fly && m_pos == FRAME - 1);
        check_eq("full", full, m_q.size() == DEPTH);
        check_eq("empty", empty, m_q.size() == 0);
        check_eq("overflow", overflow, m_ovf);
        if (tx_done) n_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [9:0] pat;
        int d0;
        int guard;

        // Reset state
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'h33, 1'b0, 1'b1);
        check_eq("rst_txd", txd, 1); check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1); check_eq("rst_full", full, 0);
        check_eq("rst_busy", busy, 0); check_eq("rst_done", tx_done, 0);
        check_eq("rst_ovf", overflow, 0);

        // Single byte 0xA5: exact waveform and pulse timing
        pat = 10'b1101001010;
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        check_eq("s1_count_c1", count, 1);
        check_eq("s1_txd_c1", txd, 1);
        for (int c = 2; c <= 42; c++) begin
            idle(1);
            if (c <= 41) check_eq("s1_txd_bit", txd, pat[(c - 2) / CPB]);
            check_eq("s1_done", tx_done, c == 41);
            check_eq("s1_busy", busy, c <= 41);
        end
        idle(4);

        // Back-to-back frames
        d0 = n_done;
        tick(1'b1, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 8'hFF, 1'b0, 1'b0);
        idle(2 * FRAME + 5);
        check_eq("s2_frames", n_done - d0, 2);

        // Fill and overflow, then clear
        d0 = n_done;
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        check_eq("s3_full", full, 1);
        check_eq("s3_ovf_set", overflow, 1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("s3_ovf_clr", overflow, 0);
        idle(5 * FRAME + 10);
        check_eq("s3_frames", n_done - d0, 5);

        // Simultaneous push/pop while full
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        guard = 0;
        while (!(m_fly && m_pos == FRAME - 1) && guard < 200) begin
            idle(1); guard++;
        end
        check_eq("s4_reach_pop", guard < 200, 1);
        check_eq("s4_count_pre", count, 4);
        tick(1'b1, 8'h5A, 1'b0, 1'b0);
        check_eq("s4_count_post", count, 4);
        check_eq("s4_ovf", overflow, 0);
        idle(6 * FRAME + 10);

        // Reset during data bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        guard = 0;
        while (!(m_fly && m_pos == 4 * CPB) && guard < 200) begin
            idle(1); guard++;
        end
        check_eq("s5_reach_bit3", guard < 200, 1);
        check_eq("s5_count_pre", count, 2);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("s5_txd", txd, 1);
        check_eq("s5_count", count, 0);
        check_eq("s5_busy", busy, 0);
        d0 = n_done;
        idle(3 * FRAME);
        check_eq("s5_no_frames", n_done - d0, 0);

        // Pointer wrap at a pace keeping the queue shallow
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b0);
            check_eq("s6_count_le2", count <= 3'd2, 1);
            idle(FRAME - 5);
        end
        idle(3 * FRAME);

        // Randomized traffic with varying write density
        for (int p = 0; p < 8; p++) begin
            int thr;
            thr = $urandom_range(0, 12);
            for (int c = 0; c < 400; c++) begin
                tick($urandom_range(0, 99) < thr, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 31) == 0, $urandom_range(0, 599) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit-direction counterpart of the peripheral UART receive path. It accepts bytes from the peripheral write decode, buffers them in a small FIFO and serializes each one onto `txd` as an 8N1 frame (start bit, 8 data bits LSB first, one stop bit). It sits between the UART data-register write strobe and the `uart_tx` pad, and exposes fill and overflow status for a future status register.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 16: `clk` cycles per bit period; minimum 2.
- `DEPTH`, default 8: FIFO entries; power of 2, minimum 2.

**Ports**
- `clk`  in  1: single clock for all logic.
- `rst`  in  1: reset, synchronous and active-high.
- `wr_en`  in  1: push `wr_data` this cycle.
- `wr_data`  in  8: byte to transmit.
- `clr_ovf`  in  1: clear the sticky `overflow` flag.
- `txd`  out  1: serial output, idle high.
- `full`  out  1: `count == DEPTH`.
- `empty`  out  1: `count == 0`.
- `count`  out  $clog2(DEPTH)+1: bytes buffered, excluding the frame in flight.
- `busy`  out  1: a frame is being shifted (FSM not IDLE).
- `tx_done`  out  1: one-cycle pulse on the last cycle of a stop bit.
- `overflow`  out  1: sticky flag for a dropped write.

## Operation

**Reset values**
- `txd`=1, `count`=0, `empty`=1, `full`=0, `busy`=0, `tx_done`=0, `overflow`=0.
- FSM = IDLE; FIFO pointers = 0.
- Reset asserted mid-frame aborts the frame immediately: `txd` is 1 the cycle after the reset edge and FIFO contents are discarded.

**FIFO**
- Circular buffer with `DEPTH` entries. Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- A write is accepted when `wr_en` is high and either `count < DEPTH` or a pop occurs in the same cycle.
- `wr_en` while full with no pop: the byte is dropped, `overflow` sets, and `count` and pointers are unchanged.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- `clr_ovf` clears `overflow`. If `clr_ovf` and a new drop occur in the same cycle, set wins.

**FSM**
- States: IDLE, START, DATA, STOP.
- A bit-period counter `baud_cnt` runs 0..CLKS_PER_BIT-1. A bit index `bit_idx` runs 0..7.
- IDLE: `txd`=1. If `!empty`, pop the head into shift register `sh`, clear `baud_cnt`, and go to START.
- START: `txd`=0. When `baud_cnt==CLKS_PER_BIT-1`, go to DATA with `bit_idx`=0.
- DATA: `txd`=`sh[0]`. At the end of each bit period, shift `sh` right. Go to STOP after `bit_idx==7`.
- STOP: `txd`=1. At the end of the period, pulse `tx_done`. If `!empty`, pop the next byte and go directly to START; otherwise go to IDLE.
- `txd` is driven from a register (no glitches).

## Timing

- Write latency: `wr_en` in cycle 0 into an empty, idle queue gives `count`=1 in cycle 1 and `txd`=0 (start bit) from cycle 2.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Each bit holds for exactly CLKS_PER_BIT cycles.
- Back-to-back frames: the next start bit begins the cycle after the previous stop bit's last cycle, with no idle gap.
- `count` decrements the cycle after the pop (IDLE→START or STOP→START).
- `busy` is high from the first START cycle through the last STOP cycle, and stays high across back-to-back frames.
- `tx_done` is high only in the final cycle of each stop bit.
- `full`, `empty` and `overflow` are registered and update the cycle after the causing event.

## Test plan

Directed scenarios; CLKS_PER_BIT=4, DEPTH=4 unless stated otherwise.

1. **Single byte.** Write 0xA5 at cycle 0 → `txd` holds 1 through cycle 1, then from cycle 2 shows 4-cycle bits 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses at cycle 41 and `busy` falls at cycle 42.
2. **Back-to-back.** Write 0x00, then 0xFF on consecutive cycles → two contiguous 40-cycle frames with no idle gap, and one `tx_done` pulse per frame.
3. **Fill and overflow.** Write 6 bytes on consecutive cycles → 1 byte in flight, 4 buffered, `full`=1, and the 6th write is dropped with `overflow`=1. Then pulse `clr_ovf` → `overflow`=0. Only 5 frames are observed on `txd`.
4. **Simultaneous push/pop at full.** With `count`=4, assert `wr_en` in the STOP→START pop cycle → the write is accepted, `count` stays 4, and `overflow` stays 0.
5. **Reset mid-frame.** Assert `rst` during DATA bit 3 with 2 bytes queued → the next cycle shows `txd`=1, `count`=0 and `busy`=0, and no further frames are sent.
6. **Pointer wrap.** Push and transmit 10 bytes (0x01..0x0A) at a pace that keeps `count`≤2 → bytes appear on `txd` in order, with no loss or duplication across the pointer wrap.
